// File: rtl/window_energy_pkg.sv
// Shared types and sizing helpers for window_energy_meter.
package window_energy_pkg;

  typedef enum logic {
    WARMUP = 1'b0,
    ACCUM  = 1'b1
  } state_e;

  localparam int WCNT_W = 16;

  // Width that holds WINDOW_LEN magnitudes of DATA_SIZE bits without wrapping.
  function automatic int acc_size(input int data_size, input int window_len);
    return data_size + $clog2(window_len);
  endfunction

endpackage

// File: rtl/window_energy_meter_sample_abs.sv
// One registered stage converting a signed sample to its unsigned magnitude.
module sample_abs #(
  parameter int DATA_SIZE = 64
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [DATA_SIZE-1:0] i_sample,
  output logic [DATA_SIZE-1:0] o_mag
);

  logic [DATA_SIZE-1:0] mag_d, mag_q;

  // Unsigned result, so the most negative input maps to 2^(DATA_SIZE-1) exactly.
  always_comb begin
    mag_d = i_sample;
    if (i_sample[DATA_SIZE-1]) mag_d = ~i_sample + DATA_SIZE'(1);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) mag_q <= '0;
    else         mag_q <= mag_d;
  end

  assign o_mag = mag_q;

endmodule

// File: rtl/window_energy_meter.sv
// Per-window L1 energy of a reference/error sample stream with convergence flag.
// Optional WINDOW_ENERGY_PEAK_EN adds o_err_peak, the largest |error| per window.
module window_energy_meter
  import window_energy_pkg::*;
#(
  parameter  int DATA_SIZE    = 64,
  parameter  int WINDOW_LEN   = 1024,
  parameter  int READ_LATENCY = 2,
  parameter  int THRESH_SHIFT = 4,
  localparam int ACC_SIZE     = acc_size(DATA_SIZE, WINDOW_LEN)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [DATA_SIZE-1:0] i_reference,
  input  logic [DATA_SIZE-1:0] i_error,
  output logic [ACC_SIZE-1:0]  o_ref_sum,
  output logic [ACC_SIZE-1:0]  o_err_sum,
  output logic                 o_valid,
  output logic                 o_converged,
`ifdef WINDOW_ENERGY_PEAK_EN
  output logic [DATA_SIZE-1:0] o_err_peak,
`endif
  output logic [WCNT_W-1:0]    o_window_cnt
);

  localparam int SCNT_W    = $clog2(WINDOW_LEN);
  localparam int WARM_LAST = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;
  localparam int WARM_W    = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
  localparam int CMP_W     = ACC_SIZE + THRESH_SHIFT;

  state_e              state_d, state_q;
  logic [WARM_W-1:0]   warm_cnt_d, warm_cnt_q;
  logic [SCNT_W-1:0]   sample_cnt_d, sample_cnt_q;

  logic                s1_vld_d, s1_vld_q;
  logic                s1_first_d, s1_first_q;
  logic                s1_last_d, s1_last_q;
  logic [DATA_SIZE-1:0] ref_mag, err_mag;

  logic [ACC_SIZE-1:0] ref_acc_d, ref_acc_q;
  logic [ACC_SIZE-1:0] err_acc_d, err_acc_q;
  logic                s2_last_d, s2_last_q;

  logic [ACC_SIZE-1:0] ref_sum_d, ref_sum_q;
  logic [ACC_SIZE-1:0] err_sum_d, err_sum_q;
  logic                valid_d, valid_q;
  logic                conv_d, conv_q;
  logic [WCNT_W-1:0]   wcnt_d, wcnt_q;

  // The reader has no valid strobe, so its pipeline fill is timed out here.
  always_comb begin
    state_d      = state_q;
    warm_cnt_d   = warm_cnt_q;
    sample_cnt_d = sample_cnt_q;
    s1_vld_d     = 1'b0;
    s1_first_d   = 1'b0;
    s1_last_d    = 1'b0;
    case (state_q)
      WARMUP: begin
        if (warm_cnt_q == WARM_W'(WARM_LAST)) state_d = ACCUM;
        else                                  warm_cnt_d = warm_cnt_q + WARM_W'(1);
      end
      ACCUM: begin
        s1_vld_d     = 1'b1;
        s1_first_d   = (sample_cnt_q == '0);
        s1_last_d    = (sample_cnt_q == SCNT_W'(WINDOW_LEN - 1));
        sample_cnt_d = s1_last_d ? '0 : sample_cnt_q + SCNT_W'(1);
      end
      default: state_d = WARMUP;
    endcase
  end

  sample_abs #(.DATA_SIZE(DATA_SIZE)) u_ref_abs (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_sample(i_reference),
    .o_mag   (ref_mag)
  );

  sample_abs #(.DATA_SIZE(DATA_SIZE)) u_err_abs (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_sample(i_error),
    .o_mag   (err_mag)
  );

  // Loading on a window's first sample lets windows abut with no idle cycle.
  always_comb begin
    ref_acc_d = ref_acc_q;
    err_acc_d = err_acc_q;
    s2_last_d = s1_vld_q & s1_last_q;
    if (s1_vld_q) begin
      ref_acc_d = s1_first_q ? ACC_SIZE'(ref_mag) : ref_acc_q + ACC_SIZE'(ref_mag);
      err_acc_d = s1_first_q ? ACC_SIZE'(err_mag) : err_acc_q + ACC_SIZE'(err_mag);
    end
  end

  always_comb begin
    ref_sum_d = ref_sum_q;
    err_sum_d = err_sum_q;
    conv_d    = conv_q;
    wcnt_d    = wcnt_q;
    valid_d   = s2_last_q;
    if (s2_last_q) begin
      ref_sum_d = ref_acc_q;
      err_sum_d = err_acc_q;
      conv_d    = (CMP_W'(err_acc_q) << THRESH_SHIFT) < CMP_W'(ref_acc_q);
      wcnt_d    = wcnt_q + WCNT_W'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= WARMUP;
      warm_cnt_q   <= '0;
      sample_cnt_q <= '0;
      s1_vld_q     <= 1'b0;
      s1_first_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      ref_acc_q    <= '0;
      err_acc_q    <= '0;
      s2_last_q    <= 1'b0;
      ref_sum_q    <= '0;
      err_sum_q    <= '0;
      valid_q      <= 1'b0;
      conv_q       <= 1'b0;
      wcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      warm_cnt_q   <= warm_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      s1_vld_q     <= s1_vld_d;
      s1_first_q   <= s1_first_d;
      s1_last_q    <= s1_last_d;
      ref_acc_q    <= ref_acc_d;
      err_acc_q    <= err_acc_d;
      s2_last_q    <= s2_last_d;
      ref_sum_q    <= ref_sum_d;
      err_sum_q    <= err_sum_d;
      valid_q      <= valid_d;
      conv_q       <= conv_d;
      wcnt_q       <= wcnt_d;
    end
  end

  assign o_ref_sum    = ref_sum_q;
  assign o_err_sum    = err_sum_q;
  assign o_valid      = valid_q;
  assign o_converged  = conv_q;
  assign o_window_cnt = wcnt_q;

`ifdef WINDOW_ENERGY_PEAK_EN
  logic [DATA_SIZE-1:0] peak_acc_d, peak_acc_q;
  logic [DATA_SIZE-1:0] peak_d, peak_q;

  always_comb begin
    peak_acc_d = peak_acc_q;
    peak_d     = peak_q;
    if (s1_vld_q) begin
      if (s1_first_q || (err_mag > peak_acc_q)) peak_acc_d = err_mag;
    end
    if (s2_last_q) peak_d = peak_acc_q;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      peak_acc_q <= '0;
      peak_q     <= '0;
    end else begin
      peak_acc_q <= peak_acc_d;
      peak_q     <= peak_d;
    end
  end

  assign o_err_peak = peak_q;
`endif

endmodule

// File: tb/tb_window_energy_meter.sv
// Table-driven scoreboard bench for window_energy_meter (WINDOW_LEN=8, READ_LATENCY=2).
module tb_window_energy_meter;

  localparam int DS = 64;
  localparam int WL = 8;
  localparam int RL = 2;
  localparam int TS = 4;
  localparam int AS = 67;

  logic          i_clock = 1'b0;
  logic          i_reset = 1'b1;
  logic [DS-1:0] i_reference = '0;
  logic [DS-1:0] i_error = '0;
  logic [AS-1:0] o_ref_sum, o_err_sum;
  logic          o_valid, o_converged;
  logic [15:0]   o_window_cnt;
`ifdef WINDOW_ENERGY_PEAK_EN
  logic [DS-1:0] o_err_peak;
`endif

  window_energy_meter #(
    .DATA_SIZE(DS), .WINDOW_LEN(WL), .READ_LATENCY(RL), .THRESH_SHIFT(TS)
  ) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_reference (i_reference),
    .i_error     (i_error),
    .o_ref_sum   (o_ref_sum),
    .o_err_sum   (o_err_sum),
    .o_valid     (o_valid),
    .o_converged (o_converged),
`ifdef WINDOW_ENERGY_PEAK_EN
    .o_err_peak  (o_err_peak),
`endif
    .o_window_cnt(o_window_cnt)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [AS-1:0] r;
    logic [AS-1:0] e;
    logic          c;
    logic [15:0]   n;
    logic [DS-1:0] p;
    int            cyc;
  } exp_t;

  typedef struct {
    logic [DS-1:0] r;
    logic [DS-1:0] e;
    bit            seq;
    int            nwin;
    logic [AS-1:0] xr;
    logic [AS-1:0] xe;
    logic          xc;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[6];
  int   ev[16] = '{1, -9, 4, 2, 0, -3, 5, 1, 2, -2, 3, -7, 1, 0, 6, -1};
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // cyc is 0 in the first cycle with reset low.
  always @(posedge i_clock) cyc <= i_reset ? 0 : cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DS-1:0] mag(input logic [DS-1:0] x);
    return x[DS-1] ? (~x + DS'(1)) : x;
  endfunction

  // Monitor: pops an expectation on every o_valid and checks outputs hold otherwise.
  initial begin
    exp_t h, e;
    h = '{r: '0, e: '0, c: 1'b0, n: '0, p: '0, cyc: 0};
    forever begin
      @(negedge i_clock);
      if (i_reset) begin
        h = '{r: '0, e: '0, c: 1'b0, n: '0, p: '0, cyc: 0};
      end else if (o_valid) begin
        if (sb.size() == 0) begin
          chk("valid_unexpected", 128'(o_valid), 128'(0));
        end else begin
          e = sb.pop_front();
          chk("valid_cycle", 128'(cyc), 128'(e.cyc));
          chk("ref_sum", 128'(o_ref_sum), 128'(e.r));
          chk("err_sum", 128'(o_err_sum), 128'(e.e));
          chk("converged", 128'(o_converged), 128'(e.c));
          chk("window_cnt", 128'(o_window_cnt), 128'(e.n));
`ifdef WINDOW_ENERGY_PEAK_EN
          chk("err_peak", 128'(o_err_peak), 128'(e.p));
`endif
          h = e;
        end
      end else begin
        if (sb.size() > 0 && cyc > sb[0].cyc) begin
          chk("valid_missing", 128'(0), 128'(1));
          void'(sb.pop_front());
        end
        chk("hold_ref", 128'(o_ref_sum), 128'(h.r));
        chk("hold_err", 128'(o_err_sum), 128'(h.e));
        chk("hold_conv", 128'(o_converged), 128'(h.c));
        chk("hold_cnt", 128'(o_window_cnt), 128'(h.n));
      end
    end
  end

  // Called just after a clock edge; leaves the bench just after the edge that ends reset.
  task automatic do_reset();
    i_reset = 1'b1;
    sb.delete();
    @(posedge i_clock); #1;
    i_reset = 1'b0;
  endtask

  task automatic drive(input vec_t v, input int stop_k);
    logic [AS-1:0] sr, se;
    logic [DS-1:0] pk, e;
    exp_t x;
    int s;
    sr = '0; se = '0; pk = '0;
    for (int k = 0; k < RL + v.nwin * WL + 4; k++) begin
      if (k == stop_k) return;
      if (k < RL) begin
        i_reference = {1'b0, {(DS-1){1'b1}}};
        i_error     = {1'b0, {(DS-1){1'b1}}};
      end else begin
        s = k - RL;
        e = v.seq ? DS'(ev[s % 16]) : v.e;
        i_reference = v.r;
        i_error     = e;
        if (s % WL == 0) begin sr = '0; se = '0; pk = '0; end
        sr = sr + AS'(mag(v.r));
        se = se + AS'(mag(e));
        if (mag(e) > pk) pk = mag(e);
        if (s % WL == WL - 1 && s / WL < v.nwin) begin
          x.r   = v.seq ? sr : v.xr;
          x.e   = v.seq ? se : v.xe;
          x.c   = v.seq ? ((71'(se) << TS) < 71'(sr)) : v.xc;
          x.n   = 16'(s / WL + 1);
          x.p   = pk;
          x.cyc = k + 3;
          sb.push_back(x);
        end
      end
      if (k == 0) begin
        @(negedge i_clock);
        chk("rst_ref", 128'(o_ref_sum), 128'(0));
        chk("rst_err", 128'(o_err_sum), 128'(0));
        chk("rst_valid", 128'(o_valid), 128'(0));
        chk("rst_cnt", 128'(o_window_cnt), 128'(0));
      end
      @(posedge i_clock); #1;
    end
    chk("sb_drained", 128'(sb.size()), 128'(0));
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{r: 64'd100, e: DS'(-3), seq: 1'b0, nwin: 3, xr: 67'd800, xe: 67'd24, xc: 1'b1};
    tbl[1] = '{r: 64'd1, e: 64'd1, seq: 1'b0, nwin: 3, xr: 67'd8, xe: 67'd8, xc: 1'b0};
    tbl[2] = '{r: 64'd1, e: 64'h8000_0000_0000_0000, seq: 1'b0, nwin: 2,
               xr: 67'd8, xe: 67'h4_0000_0000_0000_0000, xc: 1'b0};
    tbl[3] = '{r: 64'd10, e: 64'd1, seq: 1'b0, nwin: 2, xr: 67'd80, xe: 67'd8, xc: 1'b0};
    tbl[4] = '{r: 64'h7FFF_FFFF_FFFF_FFFF, e: 64'd0, seq: 1'b0, nwin: 2,
               xr: 67'h3_FFFF_FFFF_FFFF_FFF8, xe: 67'd0, xc: 1'b1};
    tbl[5] = '{r: 64'd100, e: 64'd0, seq: 1'b1, nwin: 2, xr: '0, xe: '0, xc: 1'b0};

    @(posedge i_clock); #1;
    for (int i = 0; i < 6; i++) begin
      do_reset();
      drive(tbl[i], -1);
    end

    // Reset while sample_cnt=5 of the second window, then one clean window.
    v = tbl[0];
    do_reset();
    drive(v, 15);
    do_reset();
    v.nwin = 1;
    drive(v, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

endmodule
